lcd_layer_mux: RTL and testbench

- Parametrised N-source pixel selector for the LCD pipeline; replaces the fixed 2-way UI/image select.
- Source switches are frame-synchronous (applied at vsync), so no torn frames.
- Adds a per-source enable mask, a background colour and a rectangular highlight-border overlay.
- Sits between the pixel generators (UI, image, future layers) and the LCD controller's data input.

---
 rtl/lcd_pkg.sv | 23 ++
 rtl/lcd_rect_border_hit.sv | 40 ++++
 rtl/lcd_layer_mux.sv | 185 ++++++++++++++++++
 tb/tb_lcd_layer_mux.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD pipeline types, panel geometry and colour constants.
// Also holds the per-byte crossfade helper used by the layer mux fade option.
package lcd_pkg;

  typedef logic [23:0] pixel_t;
  typedef logic [10:0] coord_t;

  localparam int H_ACT = 800;
  localparam int V_ACT = 480;

  localparam pixel_t COLOR_BLACK = 24'h000000;
  localparam pixel_t COLOR_WHITE = 24'hFFFFFF;

  // Weighted mix of one colour byte: (a*(16-k) + b*k) >> 4, k in 0..16.
  function automatic logic [7:0] blend8(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [4:0] k);
    logic [12:0] sum;
    sum = 13'(a) * 13'(5'd16 - k) + 13'(b) * 13'(k);
    return sum[11:4];
  endfunction

endpackage

// File: rtl/lcd_rect_border_hit.sv
// Combinational test: is (x,y) on the BORDER_W-thick frame of an inclusive rectangle.
// Uses one extra bit of headroom so edges at 0 or the max coordinate never wrap.
module lcd_rect_border_hit #(
  parameter int COORD_W  = 11,
  parameter int BORDER_W = 2
) (
  input  logic               en_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] x0_i,
  input  logic [COORD_W-1:0] y0_i,
  input  logic [COORD_W-1:0] x1_i,
  input  logic [COORD_W-1:0] y1_i,
  output logic               hit_o
);

  localparam int EW = COORD_W + 1;
  localparam logic [EW-1:0] BW = EW'(BORDER_W);

  logic [EW-1:0] x, y, x0, y0, x1, y1;
  logic          in_x, in_y, near_edge;

  assign x  = {1'b0, x_i};
  assign y  = {1'b0, y_i};
  assign x0 = {1'b0, x0_i};
  assign y0 = {1'b0, y0_i};
  assign x1 = {1'b0, x1_i};
  assign y1 = {1'b0, y1_i};

  // An inverted rectangle fails both range tests, so it never hits.
  assign in_x = (x >= x0) && (x <= x1);
  assign in_y = (y >= y0) && (y <= y1);

  // "x > x1 - BW" written as "x + BW > x1" to avoid underflow near zero.
  assign near_edge = (x < x0 + BW) || (x + BW > x1) ||
                     (y < y0 + BW) || (y + BW > y1);

  assign hit_o = en_i && in_x && in_y && near_edge;

endmodule

// File: rtl/lcd_layer_mux.sv
// N-source LCD pixel selector with frame-synchronous source switching,
// enable mask, background colour and highlight border overlay.
// Define LCD_LAYER_MUX_FADE_EN for a 16-frame crossfade on each switch (adds fade_busy, latency 2).
module lcd_layer_mux
  import lcd_pkg::*;
#(
  parameter int               NUM_SRC   = 4,
  parameter int               PIX_W     = 24,
  parameter int               COORD_W   = 11,
  parameter int               SEL_W     = 3,
  parameter logic [PIX_W-1:0] BG_COLOR  = PIX_W'(COLOR_BLACK),
  parameter int               BORDER_W  = 2,
  parameter bit               VSYNC_POL = 1'b0
) (
  input  logic                     lcd_clk_33m,
  input  logic                     rst_n,
  input  logic                     vsync,
  input  logic [COORD_W-1:0]       pix_x,
  input  logic [COORD_W-1:0]       pix_y,
  input  logic [NUM_SRC*PIX_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_en,
  input  logic [SEL_W-1:0]         sel_req,
  input  logic                     sel_req_valid,
  input  logic                     ovl_en,
  input  logic [COORD_W-1:0]       ovl_x0,
  input  logic [COORD_W-1:0]       ovl_y0,
  input  logic [COORD_W-1:0]       ovl_x1,
  input  logic [COORD_W-1:0]       ovl_y1,
  input  logic [PIX_W-1:0]         ovl_color,
  output logic [PIX_W-1:0]         pix_data,
  output logic [SEL_W-1:0]         active_sel,
  output logic                     sel_pending,
  output logic                     sel_err
`ifdef LCD_LAYER_MUX_FADE_EN
  ,
  output logic                     fade_busy
`endif
);

  localparam logic [SEL_W:0] NUM_SRC_W = (SEL_W + 1)'(NUM_SRC);

  logic             vsync_q;
  logic             frame_start;
  logic             commit;
  logic             req_ok, req_bad;

  logic [SEL_W-1:0] active_sel_q, active_sel_d;
  logic [SEL_W-1:0] pending_sel_q, pending_sel_d;
  logic             sel_pending_q, sel_pending_d;
  logic             sel_err_q, sel_err_d;

  logic             ovl_hit;
  logic [PIX_W-1:0] new_pix;
  logic [PIX_W-1:0] pix_data_q, pix_data_d;

  // Source pixel after the enable mask; disabled or out-of-range selects give BG_COLOR.
  function automatic logic [PIX_W-1:0] src_pixel(input logic [SEL_W-1:0]         s,
                                                  input logic [NUM_SRC*PIX_W-1:0] d,
                                                  input logic [NUM_SRC-1:0]       en);
    logic [PIX_W-1:0] p;
    p = BG_COLOR;
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((s == SEL_W'(i)) && en[i]) p = d[i*PIX_W +: PIX_W];
    end
    return p;
  endfunction

  assign frame_start = (vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);
  assign commit      = frame_start && sel_pending_q;
  assign req_ok      = sel_req_valid && ({1'b0, sel_req} < NUM_SRC_W);
  assign req_bad     = sel_req_valid && !req_ok;

  // Commit first, then a coincident request becomes pending for the next frame.
  always_comb begin
    active_sel_d  = active_sel_q;
    pending_sel_d = pending_sel_q;
    sel_pending_d = sel_pending_q;
    sel_err_d     = sel_err_q;
    if (commit) begin
      active_sel_d  = pending_sel_q;
      sel_pending_d = 1'b0;
    end
    if (req_ok) begin
      pending_sel_d = sel_req;
      sel_pending_d = 1'b1;
    end
    if (req_bad) sel_err_d = 1'b1;
  end

  always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q       <= ~VSYNC_POL;
      active_sel_q  <= '0;
      pending_sel_q <= '0;
      sel_pending_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      vsync_q       <= vsync;
      active_sel_q  <= active_sel_d;
      pending_sel_q <= pending_sel_d;
      sel_pending_q <= sel_pending_d;
      sel_err_q     <= sel_err_d;
    end
  end

  lcd_rect_border_hit #(
    .COORD_W  (COORD_W),
    .BORDER_W (BORDER_W)
  ) u_border_hit (
    .en_i  (ovl_en),
    .x_i   (pix_x),
    .y_i   (pix_y),
    .x0_i  (ovl_x0),
    .y0_i  (ovl_y0),
    .x1_i  (ovl_x1),
    .y1_i  (ovl_y1),
    .hit_o (ovl_hit)
  );

  assign new_pix = src_pixel(active_sel_q, src_data, src_en);

`ifdef LCD_LAYER_MUX_FADE_EN
  logic [SEL_W-1:0] old_sel_q;
  logic [4:0]       fade_k_q;
  logic             fade_busy_q;
  logic [PIX_W-1:0] old_pix_q, new_pix_q, ovl_color_q, blend_d;
  logic [4:0]       k_s1_q;
  logic             ovl_hit_q;

  // k counts 1..16 across frames; the boundary after frame 16 ends the fade.
  always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      old_sel_q   <= '0;
      fade_k_q    <= 5'd16;
      fade_busy_q <= 1'b0;
    end else if (commit) begin
      old_sel_q   <= active_sel_q;
      fade_k_q    <= 5'd1;
      fade_busy_q <= 1'b1;
    end else if (frame_start && fade_busy_q) begin
      if (fade_k_q == 5'd16) fade_busy_q <= 1'b0;
      else                   fade_k_q    <= fade_k_q + 5'd1;
    end
  end

  always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      old_pix_q   <= '0;
      new_pix_q   <= '0;
      ovl_color_q <= '0;
      k_s1_q      <= 5'd16;
      ovl_hit_q   <= 1'b0;
    end else begin
      old_pix_q   <= src_pixel(old_sel_q, src_data, src_en);
      new_pix_q   <= new_pix;
      ovl_color_q <= ovl_color;
      k_s1_q      <= fade_busy_q ? fade_k_q : 5'd16;
      ovl_hit_q   <= ovl_hit;
    end
  end

  always_comb begin
    blend_d = '0;
    for (int b = 0; b < PIX_W / 8; b++) begin
      blend_d[b*8 +: 8] = blend8(old_pix_q[b*8 +: 8], new_pix_q[b*8 +: 8], k_s1_q);
    end
  end

  assign pix_data_d = ovl_hit_q ? ovl_color_q : blend_d;
  assign fade_busy  = fade_busy_q;
`else
  assign pix_data_d = ovl_hit ? ovl_color : new_pix;
`endif

  always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
    if (!rst_n) pix_data_q <= '0;
    else        pix_data_q <= pix_data_d;
  end

  assign pix_data    = pix_data_q;
  assign active_sel  = active_sel_q;
  assign sel_pending = sel_pending_q;
  assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_lcd_layer_mux.sv
// Self-checking bench for lcd_layer_mux (default build): directed steps then random traffic
// compared every cycle against a behavioural frame/overlay model.
module tb_lcd_layer_mux;

  localparam int NS = 4;
  localparam int PW = 24;
  localparam int CW = 11;
  localparam int SW = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             vsync;
  logic [CW-1:0]    pix_x, pix_y;
  logic [NS*PW-1:0] src_data;
  logic [NS-1:0]    src_en;
  logic [SW-1:0]    sel_req;
  logic             sel_req_valid;
  logic             ovl_en;
  logic [CW-1:0]    ovl_x0, ovl_y0, ovl_x1, ovl_y1;
  logic [PW-1:0]    ovl_color;
  logic [PW-1:0]    pix_data;
  logic [SW-1:0]    active_sel;
  logic             sel_pending;
  logic             sel_err;
`ifdef LCD_LAYER_MUX_FADE_EN
  logic             fade_busy;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers for the selection, frame-boundary tracker on vsync.
  int   m_active, m_pending;
  bit   m_pend, m_err;
  logic m_prev_vs;

  always #15 clk = ~clk;

  lcd_layer_mux dut (
    .lcd_clk_33m   (clk),
    .rst_n         (rst_n),
    .vsync         (vsync),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .src_data      (src_data),
    .src_en        (src_en),
    .sel_req       (sel_req),
    .sel_req_valid (sel_req_valid),
    .ovl_en        (ovl_en),
    .ovl_x0        (ovl_x0),
    .ovl_y0        (ovl_y0),
    .ovl_x1        (ovl_x1),
    .ovl_y1        (ovl_y1),
    .ovl_color     (ovl_color),
    .pix_data      (pix_data),
    .active_sel    (active_sel),
    .sel_pending   (sel_pending),
    .sel_err       (sel_err)
`ifdef LCD_LAYER_MUX_FADE_EN
    ,
    .fade_busy     (fade_busy)
`endif
  );

  function automatic bit ovl_hit_ref(int x, int y, int x0, int y0, int x1, int y1, bit en);
    if (!en) return 1'b0;
    if (x < x0 || x > x1 || y < y0 || y > y1) return 1'b0;
    return (x < x0 + 2) || (x > x1 - 2) || (y < y0 + 2) || (y > y1 - 2);
  endfunction

  function automatic logic [PW-1:0] pix_ref(int sel);
    if (ovl_hit_ref(int'(pix_x), int'(pix_y), int'(ovl_x0), int'(ovl_y0),
                    int'(ovl_x1), int'(ovl_y1), ovl_en))
      return ovl_color;
    if (!src_en[sel]) return 24'h000000;
    return src_data[sel*PW +: PW];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active  = 0;
    m_pending = 0;
    m_pend    = 1'b0;
    m_err     = 1'b0;
    m_prev_vs = 1'b1;
  endtask

  // One clock: predict from the current inputs, advance the model, then compare.
  task automatic step();
    logic [PW-1:0] e_pix;
    bit            boundary;
    e_pix    = pix_ref(m_active);
    boundary = (vsync == 1'b0) && (m_prev_vs == 1'b1);
    if (boundary && m_pend) begin
      m_active = m_pending;
      m_pend   = 1'b0;
    end
    if (sel_req_valid) begin
      if (int'(sel_req) < NS) begin
        m_pending = int'(sel_req);
        m_pend    = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    m_prev_vs = vsync;
    @(posedge clk);
    #1;
    chk("pix_data", 32'(pix_data), 32'(e_pix));
    chk("active_sel", 32'(active_sel), 32'(m_active));
    chk("sel_pending", 32'(sel_pending), 32'(m_pend));
    chk("sel_err", 32'(sel_err), 32'(m_err));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame_edge();
    vsync = 1'b0;
    run(3);
    vsync = 1'b1;
  endtask

  task automatic request(input int v);
    sel_req       = SW'(v);
    sel_req_valid = 1'b1;
    step();
    sel_req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_pix_data", 32'(pix_data), 32'h0);
    chk("rst_active_sel", 32'(active_sel), 32'h0);
    chk("rst_sel_pending", 32'(sel_pending), 32'h0);
    chk("rst_sel_err", 32'(sel_err), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic pick_rect();
    int lo, w;
    for (int axis = 0; axis < 2; axis++) begin
      case ($urandom_range(0, 3))
        0:       lo = int'($urandom_range(0, 2047));
        1:       lo = int'($urandom_range(0, 3));
        2:       lo = int'($urandom_range(2040, 2047));
        default: lo = int'($urandom_range(95, 110));
      endcase
      w = int'($urandom_range(0, 10));
      if (axis == 0) begin
        ovl_x0 = CW'(lo);
        ovl_x1 = CW'((lo + w > 2047) ? 2047 : lo + w);
        if ($urandom_range(0, 7) == 0) begin
          ovl_x0 = ovl_x1 + CW'(1 + (w % 3));
          if (ovl_x0 < ovl_x1) ovl_x0 = 11'd2047;
        end
      end else begin
        ovl_y0 = CW'(lo);
        ovl_y1 = CW'((lo + w > 2047) ? 2047 : lo + w);
        if ($urandom_range(0, 7) == 0) begin
          ovl_y0 = ovl_y1 + CW'(1 + (w % 3));
          if (ovl_y0 < ovl_y1) ovl_y0 = 11'd2047;
        end
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    vsync         = 1'b1;
    pix_x         = '0;
    pix_y         = '0;
    src_data      = {24'h030303, 24'h020202, 24'h010101, 24'h000000};
    src_en        = 4'b1111;
    sel_req       = '0;
    sel_req_valid = 1'b0;
    ovl_en        = 1'b0;
    ovl_x0        = 11'd100;
    ovl_y0        = 11'd100;
    ovl_x1        = 11'd109;
    ovl_y1        = 11'd109;
    ovl_color     = 24'hFF0000;
    model_reset();
    #1;
    do_reset();

    // Source 0 after reset
    step();
    chk("post_rst_pix", 32'(pix_data), 32'h000000);
    run(2);

    // Mid-frame request holds until the vsync edge
    request(2);
    chk("pend_set", 32'(sel_pending), 32'h1);
    run(5);
    chk("held_sel0", 32'(active_sel), 32'h0);
    vsync = 1'b0;
    step();
    step();
    chk("first_after_edge", 32'(pix_data), 32'h020202);
    run(2);
    vsync = 1'b1;
    run(10);

    // Last request in a frame wins
    request(1);
    run(3);
    request(3);
    run(3);
    frame_edge();
    run(2);
    chk("last_wins", 32'(active_sel), 32'h3);

    // Invalid request sets the sticky error and leaves pending intact
    request(1);
    request(5);
    chk("err_set", 32'(sel_err), 32'h1);
    chk("err_pend_kept", 32'(sel_pending), 32'h1);
    frame_edge();
    run(2);
    chk("err_commit_prev", 32'(active_sel), 32'h1);

    // Disabled active source shows background
    request(2);
    frame_edge();
    run(2);
    src_en = 4'b1011;
    run(2);
    chk("bg_disabled", 32'(pix_data), 32'h000000);
    src_en = 4'b1111;
    run(2);
    chk("reenabled", 32'(pix_data), 32'h020202);

    // Request coincident with the frame boundary waits a frame
    run(5);
    vsync         = 1'b0;
    sel_req       = 3'd3;
    sel_req_valid = 1'b1;
    step();
    sel_req_valid = 1'b0;
    run(2);
    vsync = 1'b1;
    chk("coinc_not_yet", 32'(active_sel), 32'h2);
    chk("coinc_pending", 32'(sel_pending), 32'h1);
    run(10);
    frame_edge();
    run(1);
    chk("coinc_commit", 32'(active_sel), 32'h3);

    // Overlay border
    ovl_en = 1'b1;
    pix_x = 11'd100; pix_y = 11'd105; step();
    chk("ovl_100_105", 32'(pix_data), 32'hFF0000);
    pix_x = 11'd108; pix_y = 11'd108; step();
    chk("ovl_108_108", 32'(pix_data), 32'hFF0000);
    pix_x = 11'd104; pix_y = 11'd104; step();
    chk("ovl_inner", 32'(pix_data), 32'h030303);
    ovl_x0 = 11'd110;
    for (int x = 95; x <= 115; x++) begin
      pix_x = CW'(x);
      pix_y = 11'd100;
      step();
      chk("ovl_empty", 32'(pix_data == 24'hFF0000), 32'h0);
    end
    ovl_x0 = 11'd100;
    ovl_en = 1'b0;

    // Asynchronous reset mid-frame
    request(1);
    run(3);
    do_reset();
    run(3);
    chk("post_reset_sel", 32'(active_sel), 32'h0);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 32 == 0) begin
        pick_rect();
        ovl_en    = 1'($urandom_range(0, 3) != 0);
        ovl_color = 24'($urandom);
      end
      src_data      = {$urandom, $urandom, $urandom};
      src_en        = NS'($urandom_range(0, 15));
      pix_x         = CW'((int'(ovl_x0) + int'($urandom_range(0, 15)) + 2048 - 3) % 2048);
      pix_y         = CW'((int'(ovl_y0) + int'($urandom_range(0, 15)) + 2048 - 3) % 2048);
      vsync         = (i % 40) < 3 ? 1'b0 : 1'b1;
      sel_req_valid = ($urandom_range(0, 7) == 0);
      sel_req       = SW'($urandom_range(0, 7));
      step();
    end
    sel_req_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
